// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - ID/EX pipeline register bus: decoded ID fields in, registered EX fields out
interface id_ex_reg_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [31:0]      id_pc_plus4;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic [31:0]      id_imm_ext;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       id_shamt;
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_branch;
    logic             id_alu_src;
    logic             id_reg_dst;
    logic [1:0]       id_alu_op;

    logic             ex_valid;
    logic [31:0]      ex_pc_plus4;
    logic [31:0]      ex_rs_data;
    logic [31:0]      ex_rt_data;
    logic [31:0]      ex_imm_ext;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_shamt;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_branch;
    logic             ex_alu_src;
    logic             ex_reg_dst;
    logic [1:0]       ex_alu_op;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output stall, flush, id_valid,
        output id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
        output id_rs, id_rt, id_rd, id_shamt,
        output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
        output id_branch, id_alu_src, id_reg_dst, id_alu_op,
        input  ex_valid,
        input  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
        input  ex_rs, ex_rt, ex_rd, ex_shamt,
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
        input  ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op,
        input  bubble_count
    );

    modport slave (
        input  stall, flush, id_valid,
        input  id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
        input  id_rs, id_rt, id_rd, id_shamt,
        input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
        input  id_branch, id_alu_src, id_reg_dst, id_alu_op,
        output ex_valid,
        output ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
        output ex_rs, ex_rt, ex_rd, ex_shamt,
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
        output ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op,
        output bubble_count
    );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, bubble insertion and bubble counter
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_reg_if.slave   bus
);
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    data_t            data_d, data_q;
    ctrl_t            ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] count_d, count_q;
    data_t            id_data;
    ctrl_t            id_ctrl;
    logic             bubble;

    always_comb begin
        id_data = '{pc_plus4: bus.id_pc_plus4, rs_data: bus.id_rs_data,
                    rt_data: bus.id_rt_data, imm_ext: bus.id_imm_ext,
                    rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd, shamt: bus.id_shamt};
        id_ctrl = '{reg_write: bus.id_reg_write, mem_to_reg: bus.id_mem_to_reg,
                    mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                    branch: bus.id_branch, alu_src: bus.id_alu_src,
                    reg_dst: bus.id_reg_dst, alu_op: bus.id_alu_op};
    end

    // A bubble is either a flush or an unstalled load of an empty ID slot.
    assign bubble = bus.flush | (~bus.stall & ~bus.id_valid);

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (bus.flush) begin
            data_d  = '0;
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            data_d  = id_data;
            ctrl_d  = bus.id_valid ? id_ctrl : '0;
            valid_d = bus.id_valid;
        end
    end

    always_comb begin
        count_d = count_q;
        if (bubble && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_pc_plus4   = data_q.pc_plus4;
    assign bus.ex_rs_data    = data_q.rs_data;
    assign bus.ex_rt_data    = data_q.rt_data;
    assign bus.ex_imm_ext    = data_q.imm_ext;
    assign bus.ex_rs         = data_q.rs;
    assign bus.ex_rt         = data_q.rt;
    assign bus.ex_rd         = data_q.rd;
    assign bus.ex_shamt      = data_q.shamt;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_branch     = ctrl_q.branch;
    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_reg_dst    = ctrl_q.reg_dst;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.bubble_count  = count_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - scoreboard bench for id_ex_reg: directed vectors, queued expectations, monitor checks
module tb_id_ex_reg;
    logic clk = 1'b0;
    logic rst;
    logic flush2;
    always #5 clk = ~clk;

    id_ex_reg_if #(.CNT_W(16)) b1();
    id_ex_reg_if #(.CNT_W(2))  b2();

    id_ex_reg #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(b1.slave));
    id_ex_reg #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b2.stall         = 1'b0;
    assign b2.flush         = flush2;
    assign b2.id_valid      = 1'b1;
    assign b2.id_pc_plus4   = b1.id_pc_plus4;
    assign b2.id_rs_data    = b1.id_rs_data;
    assign b2.id_rt_data    = b1.id_rt_data;
    assign b2.id_imm_ext    = b1.id_imm_ext;
    assign b2.id_rs         = b1.id_rs;
    assign b2.id_rt         = b1.id_rt;
    assign b2.id_rd         = b1.id_rd;
    assign b2.id_shamt      = b1.id_shamt;
    assign b2.id_reg_write  = b1.id_reg_write;
    assign b2.id_mem_to_reg = b1.id_mem_to_reg;
    assign b2.id_mem_read   = b1.id_mem_read;
    assign b2.id_mem_write  = b1.id_mem_write;
    assign b2.id_branch     = b1.id_branch;
    assign b2.id_alu_src    = b1.id_alu_src;
    assign b2.id_reg_dst    = b1.id_reg_dst;
    assign b2.id_alu_op     = b1.id_alu_op;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, sh;
        logic [8:0]  ctrl;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, sh;
        logic [8:0]  ctrl;
        logic        valid;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        out_t        o;
        logic [15:0] hand_cnt;
    } exp_t;

    out_t       m;
    exp_t       q1[$];
    logic [1:0] q2[$];
    int         total = 0;
    int         bad   = 0;

    function automatic in_t mk(input logic v, input logic [31:0] pc, rsd, rtd, imm,
                               input logic [4:0] rs, rt, rd, sh, input logic [8:0] ctrl);
        in_t r;
        r = '{valid: v, pc: pc, rsd: rsd, rtd: rtd, imm: imm,
              rs: rs, rt: rt, rd: rd, sh: sh, ctrl: ctrl};
        return r;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.pc    = b1.ex_pc_plus4;
        a.rsd   = b1.ex_rs_data;
        a.rtd   = b1.ex_rt_data;
        a.imm   = b1.ex_imm_ext;
        a.rs    = b1.ex_rs;
        a.rt    = b1.ex_rt;
        a.rd    = b1.ex_rd;
        a.sh    = b1.ex_shamt;
        a.ctrl  = {b1.ex_reg_write, b1.ex_mem_to_reg, b1.ex_mem_read, b1.ex_mem_write,
                   b1.ex_branch, b1.ex_alu_src, b1.ex_reg_dst, b1.ex_alu_op};
        a.valid = b1.ex_valid;
        a.cnt   = b1.bubble_count;
        return a;
    endfunction

    task automatic step(input logic r, f, s, input in_t i, input logic [15:0] hc,
                        input logic f2, input logic [1:0] hs);
        @(negedge clk);
        rst      = r;
        b1.flush = f;
        b1.stall = s;
        flush2   = f2;
        b1.id_valid    = i.valid;
        b1.id_pc_plus4 = i.pc;
        b1.id_rs_data  = i.rsd;
        b1.id_rt_data  = i.rtd;
        b1.id_imm_ext  = i.imm;
        b1.id_rs       = i.rs;
        b1.id_rt       = i.rt;
        b1.id_rd       = i.rd;
        b1.id_shamt    = i.sh;
        {b1.id_reg_write, b1.id_mem_to_reg, b1.id_mem_read, b1.id_mem_write,
         b1.id_branch, b1.id_alu_src, b1.id_reg_dst, b1.id_alu_op} = i.ctrl;
        // Reference behaviour: rst > flush > stall > load.
        if (r) begin
            m = '0;
        end else if (f) begin
            m = '{pc: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, rd: 0, sh: 0,
                  ctrl: 0, valid: 0, cnt: (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1};
        end else if (!s) begin
            m.pc = i.pc; m.rsd = i.rsd; m.rtd = i.rtd; m.imm = i.imm;
            m.rs = i.rs; m.rt = i.rt; m.rd = i.rd; m.sh = i.sh;
            m.ctrl  = i.valid ? i.ctrl : 9'd0;
            m.valid = i.valid;
            if (!i.valid && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        end
        q1.push_back('{o: m, hand_cnt: hc});
        if (f2) q2.push_back(hs);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t       e;
        out_t       a;
        logic [1:0] hs;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = sample();
            total++;
            if (a !== e.o) begin
                bad++;
                $display("FAIL ex_regs got=%h want=%h", a, e.o);
            end
            total++;
            if (a.cnt !== e.hand_cnt) begin
                bad++;
                $display("FAIL bubble_count got=%0d want=%0d", a.cnt, e.hand_cnt);
            end
        end
        if (q2.size() > 0) begin
            hs = q2.pop_front();
            total++;
            if (b2.bubble_count !== hs) begin
                bad++;
                $display("FAIL sat_count got=%0d want=%0d", b2.bubble_count, hs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    in_t va, vb, vp, vi;

    initial begin
        rst = 1'b1; flush2 = 1'b0; b1.stall = 1'b0; b1.flush = 1'b0;
        va = mk(1'b1, 32'h0000_1004, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0010,
                5'd1, 5'd2, 5'd3, 5'd4, 9'b110010101);
        vb = mk(1'b1, 32'h0000_2008, 32'hCCCC_0003, 32'hDDDD_0004, 32'hFFFF_FFF0,
                5'd5, 5'd6, 5'd7, 5'd8, 9'b001101011);
        vp = mk(1'b1, 32'h0000_0040, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_8004,
                5'd10, 5'd11, 5'd9, 5'd0, 9'b100000010);
        vi = mk(1'b0, 32'h0000_0050, 32'h0000_1234, 32'h0000_5678, 32'h0000_0007,
                5'd12, 5'd13, 5'd14, 5'd15, 9'b000100000);

        step(1'b1, 1'b1, 1'b1, va, 16'd0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, vb, 16'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, vp, 16'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, va, 16'd0, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, vb, 16'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, vb, 16'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b1, va, 16'd1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, vi, 16'd2, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, vi, 16'd2, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b1, vb, 16'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, vi, 16'd1, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, vi, 16'd2, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b1, 2'd1);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b1, 2'd2);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b0, va, 16'd2, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b0, vb, 16'd2, 1'b0, 2'd0);

        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (q1.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", q1.size(), q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of the bubble counter.
REQ-002 Clock and reset SHALL be: one clock, clk; reset, rst, synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold all registered outputs.
REQ-006 flush  in  1  load a bubble (squash the ID instruction).
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  32 each  PC+4, register-file read data, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd, id_shamt  in  5 each  register specifiers and shift amount.
REQ-010 id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded control.
REQ-011 id_alu_op  in  2  ALU operation class.
REQ-012 ex_* outputs  out  same width as each id_* input above (excluding id_valid)  registered copies for the EX stage.
REQ-013 ex_valid  out  1  EX-stage instruction is real.
REQ-014 bubble_count  out  CNT_W  saturating count of bubbles inserted.

Function
REQ-015 The block SHALL be a single-stage register with 1-cycle latency: an ID value loaded at edge N SHALL appear on ex_* after edge N.
REQ-016 Per-edge priority SHALL be rst > flush > stall > load.
REQ-017 Load (no rst, no flush, no stall) with id_valid=1: all ex_* SHALL take id_* values; ex_valid=1.
REQ-018 Load with id_valid=0: data fields SHALL capture id_*; all control outputs and ex_valid SHALL be 0 (bubble).
REQ-019 Flush: all ex_* outputs (data and control) SHALL be 0; ex_valid=0.
REQ-020 Flush asserted together with stall SHALL act as a flush; stall is ignored.
REQ-021 Stall (no flush): every output, including ex_valid and bubble_count, SHALL hold its value.
REQ-022 Control outputs SHALL never be nonzero while ex_valid=0.
REQ-023 bubble_count SHALL increment by 1 on each edge that loads a bubble per REQ-018 or REQ-019.
REQ-024 bubble_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 The 32-bit fields SHALL pass unmodified; no extension or arithmetic is performed here, and id_imm_ext is already 32-bit sign-extended.
REQ-026 Outputs SHALL change only at rising clk edges; there is no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 at an edge SHALL clear all ex_* outputs, ex_valid, and bubble_count to 0, regardless of flush, stall, and id_valid.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; the first post-reset load follows REQ-017 or REQ-018.
REQ-029 A reset cycle SHALL NOT count as a bubble.

Verification
REQ-030 Reset: rst=1 for 2 edges with id_* nonzero, then release -> all outputs 0, bubble_count=0.
REQ-031 Pass-through: id_valid=1, id_imm_ext=32'hFFFF8004, id_rd=5'd9, id_reg_write=1, id_alu_op=2'b10 -> next edge ex_imm_ext=32'hFFFF8004, ex_rd=9, ex_reg_write=1, ex_alu_op=2'b10, ex_valid=1.
REQ-032 Stall: load instruction A, then stall=1 for 3 edges while id_* changes to B -> ex_* stays A, bubble_count unchanged; stall=0 -> ex_* becomes B.
REQ-033 Flush vs stall: flush=1 and stall=1 with a valid instruction -> all ex_* are 0, ex_valid=0, and bubble_count increments by 1.
REQ-034 Invalid load: id_valid=0, id_mem_write=1, id_rs_data=32'h1234 -> ex_mem_write=0, ex_valid=0, ex_rs_data=32'h1234, and bubble_count increments by 1.
REQ-035 Saturation: CNT_W=2 with 5 consecutive flushes -> bubble_count reads 1, 2, 3, 3, 3.
